muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Parametrised iterative RV M-extension execute unit. Handles MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU for an XLEN-bit datapath.
- Sits in the EX stage beside the main ALU and decodes funct3 internally.
- Accepts one operation at a time through a valid/ready handshake and holds its result until the pipeline takes it.
- Division special cases complete on a short path.

Parameters:
- XLEN, 32: operand/result width; must be even and ≥ 8.
- CNT_W, $clog2(XLEN)+1: iteration counter width; derived, not to be overridden.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill; discards any in-flight or held operation.
- valid_i  in  1  operation request.
- ready_o  out  1  unit can accept a request.
- funct3  in  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a_i  in  XLEN  rs1 operand.
- b_i  in  XLEN  rs2 operand.
- valid_o  out  1  result available.
- ready_i  in  1  consumer takes the result.
- result_o  out  XLEN  result.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, ready_o=1, valid_o=0, result_o=0, counter=0.
  - Reset mid-operation abandons the operation immediately.
- States: IDLE, CALC, DONE.
- IDLE:
  - ready_o=1.
  - Accept on a rising edge with valid_i=1 and flush=0.
  - At the accept edge, latch funct3 and the operand magnitudes. Signed operands are signed for MULH/DIV/REM, a only for MULHSU, neither for MULHU/DIVU/REMU/MUL.
  - Latch the result sign flags and load counter=XLEN.
- Short path, IDLE→DONE directly:
  - DIV/DIVU with b=0: quotient = all ones.
  - REM/REMU with b=0: result = a.
  - DIV with a=MIN_INT and b=−1: result=MIN_INT.
  - REM with a=MIN_INT and b=−1: result=0.
  - valid_o is asserted the cycle after the accept edge.
- CALC:
  - One radix-2 step per cycle; counter decrements.
  - Multiply: shift-add into a 2·XLEN product register.
  - Divide: restoring shift-subtract, producing XLEN-bit quotient and remainder.
  - After XLEN steps (counter reaches 0), apply sign fix-up and go to DONE. Quotient negated if operand signs differ; remainder takes the dividend sign; product negated if effective signs differ.
  - Selection: MUL = low XLEN bits of the product; MULH/MULHSU/MULHU = high XLEN bits.
  - Normal latency: valid_o rises exactly XLEN+1 cycles after the accept edge.
- DONE:
  - valid_o=1 and ready_o=0.
  - result_o is stable until the handshake.
  - On an edge with ready_i=1, go to IDLE; valid_o=0 on the next cycle.
  - No back-to-back accept in the same edge as the result handshake: ready_o is 0 in DONE.
- ready_o=0 in CALC and DONE; valid_i is ignored there.
- flush=1 from any state:
  - Next state IDLE, valid_o=0, no result delivered.
  - flush overrides a simultaneous accept (nothing latched) and a simultaneous result handshake.
- result_o holds its last value in IDLE. Only valid_o qualifies it.
- a_i, b_i and funct3 may change after the accept edge without effect.

Test Plan:
- XLEN=32, MUL a=0x0000_0007, b=0xFFFF_FFFD (−3) -> result 0xFFFF_FFEB; valid_o at accept+33 cycles.
- MULH a=0x8000_0000, b=0x8000_0000 -> 0x4000_0000. MULHU same operands -> 0x4000_0000. MULHSU a=0xFFFF_FFFF, b=0xFFFF_FFFF -> 0xFFFF_FFFF.
- DIV a=−7, b=2 -> 0xFFFF_FFFD (−3). REM a=−7, b=2 -> 0xFFFF_FFFF (−1). DIVU a=0xFFFF_FFFF, b=0x10 -> 0x0FFF_FFFF.
- Short path:
  - DIVU b=0 -> 0xFFFF_FFFF.
  - REM a=0x1234, b=0 -> 0x1234.
  - DIV a=0x8000_0000, b=0xFFFF_FFFF -> 0x8000_0000.
  - REM, same operands -> 0.
  - Each has valid_o at accept+1 cycle.
- Backpressure: hold ready_i=0 for 5 cycles after valid_o -> result_o and valid_o stable, ready_o=0. Raise ready_i -> IDLE next cycle, ready_o=1.
- Flush and reset:
  - flush at CALC cycle 10 -> IDLE next cycle, no valid_o; a following MUL 3×4 returns 12.
  - reset_n pulsed low mid-CALC, asynchronous to clk -> outputs immediately ready_o=1, valid_o=0, result_o=0.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX-stage issue logic and the M-extension unit.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            valid_i;
  logic            ready_o;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] result_o;

  modport master (
    output flush, valid_i, funct3, a_i, b_i, ready_i,
    input  ready_o, valid_o, result_o
  );

  modport slave (
    input  flush, valid_i, funct3, a_i, b_i, ready_i,
    output ready_o, valid_o, result_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV M-extension unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with sign fix-up folded into the last step.
// Division by zero and signed overflow bypass the iteration.
module muldiv_unit #(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input logic          clk,
  input logic          reset_n,
  muldiv_unit_if.slave io
);

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;   // multiplicand |a| or divisor |b|
  logic [2*XLEN-1:0] acc_q, acc_d;     // {hi, lo}: product, or {remainder, quotient}
  logic              neg_q, neg_d;     // final result must be negated
  logic [XLEN-1:0]   res_q, res_d;

  // operand decode at the issue boundary
  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_by0, div_ovf;

  // Which operands are interpreted as signed for the requested op.
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    unique case (io.funct3)
      3'b001, 3'b100, 3'b110: begin a_sgn = 1'b1; b_sgn = 1'b1; end
      3'b010:                 a_sgn = 1'b1;
      default: ;
    endcase
  end

  assign a_neg   = a_sgn & io.a_i[XLEN-1];
  assign b_neg   = b_sgn & io.b_i[XLEN-1];
  assign a_mag   = a_neg ? -io.a_i : io.a_i;
  assign b_mag   = b_neg ? -io.b_i : io.b_i;
  assign div_by0 = io.funct3[2] && (io.b_i == '0);
  assign div_ovf = io.funct3[2] && !io.funct3[0] && (io.a_i == MIN_INT) && (&io.b_i);

  // one iteration step and the sign-corrected final result
  logic [XLEN:0]     mul_sum, div_rsh, div_diff;
  logic [2*XLEN-1:0] mul_nxt, div_nxt, step_nxt, prod_fix;
  logic [XLEN-1:0]   q_fix, r_fix, fin;

  // Radix-2 step: multiply adds then shifts right; divide shifts left and trial-subtracts.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
    mul_nxt  = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    div_rsh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = div_rsh - {1'b0, opnd_q};
    div_nxt  = div_diff[XLEN] ? {div_rsh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    step_nxt = op_q[2] ? div_nxt : mul_nxt;
  end

  // Apply the latched sign and pick the architectural result half.
  always_comb begin
    prod_fix = neg_q ? -step_nxt : step_nxt;
    q_fix    = neg_q ? -step_nxt[XLEN-1:0] : step_nxt[XLEN-1:0];
    r_fix    = neg_q ? -step_nxt[2*XLEN-1:XLEN] : step_nxt[2*XLEN-1:XLEN];
    unique case (op_q)
      3'b000:                 fin = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin = q_fix;
      default:                fin = r_fix;
    endcase
  end

  // Next-state and datapath load; flush wins over accept and result handshake.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    res_d   = res_q;
    if (io.flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (io.valid_i) begin
          op_d  = io.funct3;
          cnt_d = CNT_W'(XLEN);
          if (io.funct3[2]) begin
            opnd_d = b_mag;
            acc_d  = {{XLEN{1'b0}}, a_mag};
            neg_d  = io.funct3[1] ? a_neg : (a_neg ^ b_neg);
          end else begin
            opnd_d = a_mag;
            acc_d  = {{XLEN{1'b0}}, b_mag};
            neg_d  = a_neg ^ b_neg;
          end
          if (div_by0) begin
            res_d   = io.funct3[1] ? io.a_i : '1;
            state_d = DONE;
          end else if (div_ovf) begin
            res_d   = io.funct3[1] ? '0 : MIN_INT;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
        CALC: begin
          acc_d = step_nxt;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            res_d   = fin;
            state_d = DONE;
          end
        end
        DONE: if (io.ready_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
    end
  end

  assign io.ready_o  = (state_q == IDLE);
  assign io.valid_o  = (state_q == DONE);
  assign io.result_o = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: literal vectors plus a cycle-level
// reference model compared against the DUT on every falling edge.
module tb_muldiv_unit;
  localparam int XLEN = 32;
  localparam logic [31:0] MIN_INT = 32'h8000_0000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  muldiv_unit_if #(.XLEN(XLEN)) io ();

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .io     (io.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Architectural result from plain 64-bit arithmetic.
  function automatic logic [31:0] mdl(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f)
      3'd0: begin p = 64'(ua * ub); return p[31:0];  end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN_INT && b == 32'hFFFF_FFFF) return MIN_INT;
        p = 64'(sa / sb); return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN_INT && b == 32'hFFFF_FFFF) return 32'h0;
        p = 64'(sa % sb); return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_short(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && (b == 0 || (!f[0] && a == MIN_INT && b == 32'hFFFF_FFFF));
  endfunction

  // Reference model: busy for XLEN edges after accept, or done immediately on the short path.
  logic        m_busy, m_done;
  int          m_age;
  logic [31:0] m_res, m_pend;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_age <= 0; m_res <= '0; m_pend <= '0;
    end else if (io.flush) begin
      m_busy <= 1'b0; m_done <= 1'b0;
    end else if (m_done) begin
      if (io.ready_i) m_done <= 1'b0;
    end else if (m_busy) begin
      m_age <= m_age + 1;
      if (m_age + 1 == XLEN) begin m_busy <= 1'b0; m_done <= 1'b1; m_res <= m_pend; end
    end else if (io.valid_i) begin
      if (is_short(io.funct3, io.a_i, io.b_i)) begin
        m_done <= 1'b1; m_res <= mdl(io.funct3, io.a_i, io.b_i);
      end else begin
        m_busy <= 1'b1; m_age <= 0; m_pend <= mdl(io.funct3, io.a_i, io.b_i);
      end
    end
  end

  // Compare DUT against the model every cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      check("cmp_valid", 32'(io.valid_o), 32'(m_done));
      check("cmp_ready", 32'(io.ready_o), 32'(!(m_busy || m_done)));
      if (m_done) check("cmp_result", io.result_o, m_res);
    end
  end

  task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    io.valid_i = 1'b1; io.funct3 = f; io.a_i = a; io.b_i = b;
    @(posedge clk); #1;
    io.valid_i = 1'b0;
    io.funct3  = ~f;                // operands change after accept: must not matter
    io.a_i     = ~a;
    io.b_i     = a ^ b;
  endtask

  task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input int hold);
    int lat;
    check({"mdl_", nm}, mdl(f, a, b), exp);
    start_op(f, a, b);
    lat = 1;
    while (!io.valid_o && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_lat"}, 32'(lat), 32'(exp_lat));
    check(nm, io.result_o, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({nm, "_hold_res"}, io.result_o, exp);
      check({nm, "_hold_vld"}, 32'(io.valid_o), 32'd1);
      check({nm, "_hold_rdy"}, 32'(io.ready_o), 32'd0);
    end
    io.ready_i = 1'b1;
    @(posedge clk); #1;
    io.ready_i = 1'b0;
    check({nm, "_ret_vld"}, 32'(io.valid_o), 32'd0);
    check({nm, "_ret_rdy"}, 32'(io.ready_o), 32'd1);
  endtask

  initial begin
    io.flush = 1'b0; io.valid_i = 1'b0; io.ready_i = 1'b0;
    io.funct3 = '0; io.a_i = '0; io.b_i = '0;
    #12;
    check("rst_ready", 32'(io.ready_o), 32'd1);
    check("rst_valid", 32'(io.valid_o), 32'd0);
    check("rst_result", io.result_o, 32'h0);
    #10 reset_n = 1'b1;
    @(posedge clk); #1;

    // normal path
    run_op("mul",    3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0);
    run_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 0);
    run_op("mulhu",  3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0);
    run_op("div",    3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33, 0);
    run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33, 0);
    run_op("divu",   3'd5, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 33, 0);
    run_op("div_pn", 3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 0);
    run_op("rem_pn", 3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33, 0);
    run_op("remu",   3'd7, 32'd100,       32'd7,         32'd2,         33, 0);
    // short path
    run_op("divu_z", 3'd5, 32'h0000_0055, 32'h0,         32'hFFFF_FFFF, 1, 0);
    run_op("div_z",  3'd4, 32'h8000_0001, 32'h0,         32'hFFFF_FFFF, 1, 0);
    run_op("rem_z",  3'd6, 32'h0000_1234, 32'h0,         32'h0000_1234, 1, 0);
    run_op("div_ov", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_op("rem_ov", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0);
    // backpressure
    run_op("bp_mul", 3'd0, 32'd1000,      32'd1000,      32'd1000000,   33, 5);

    // flush mid-CALC
    start_op(3'd0, 32'd5, 32'd9);
    repeat (9) begin @(posedge clk); #1; end
    io.flush = 1'b1;
    @(posedge clk); #1;
    io.flush = 1'b0;
    check("flush_vld", 32'(io.valid_o), 32'd0);
    check("flush_rdy", 32'(io.ready_o), 32'd1);
    repeat (40) @(posedge clk);
    #1;
    run_op("post_flush_mul", 3'd0, 32'd3, 32'd4, 32'd12, 33, 0);

    // flush together with accept: nothing latched
    io.valid_i = 1'b1; io.flush = 1'b1; io.funct3 = 3'd5; io.a_i = 32'd9; io.b_i = 32'd0;
    @(posedge clk); #1;
    io.valid_i = 1'b0; io.flush = 1'b0;
    check("flush_acc_vld", 32'(io.valid_o), 32'd0);
    check("flush_acc_rdy", 32'(io.ready_o), 32'd1);

    // flush together with result handshake in DONE
    start_op(3'd5, 32'd9, 32'd0);
    io.flush = 1'b1; io.ready_i = 1'b1;
    @(posedge clk); #1;
    io.flush = 1'b0; io.ready_i = 1'b0;
    check("flush_done_vld", 32'(io.valid_o), 32'd0);

    // async reset mid-CALC
    start_op(3'd4, 32'd100, 32'd3);
    repeat (5) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("arst_ready", 32'(io.ready_o), 32'd1);
    check("arst_valid", 32'(io.valid_o), 32'd0);
    check("arst_result", io.result_o, 32'h0);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    run_op("post_rst_div", 3'd4, 32'd100, 32'd3, 32'd33, 33, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
